// File: rtl/rvx_hazard_pkg.sv
// ============================================================================
// Module  : rvx_hazard_pkg
// Brief   : Shared types for the pipeline hazard controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rvx_hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        MC_IDLE = 2'b00,
        MC_BUSY = 2'b01,
        MC_DONE = 2'b10
    } mc_state_t;

    // The memory stage holds the younger result, so it wins over writeback.
    function automatic fwd_sel_t fwd_pick(input logic hit_m, input logic hit_w);
        if (hit_m)
            return FWD_MEM;
        else if (hit_w)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
// ============================================================================
// Module  : sat_counter
// Brief   : Saturating up-counter with synchronous clear (clear wins).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count_o
);

    localparam logic [W-1:0] c_max = '1;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (inc && (count_q != c_max))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module  : hazard_ctrl
// Brief   : Load-use / multi-cycle stall, branch flush and operand forwarding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
    import rvx_hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              ResultSrcE0,
    input  logic              PCSrcE,
    input  logic              McStartE,
    input  logic              CntClr,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              McBusy,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  FlushCnt
);

    localparam int              c_cw       = $clog2(MC_LAT) + 1;
    localparam bit              c_mc_en    = (MC_LAT >= 2);
    localparam bit              c_use_busy = (MC_LAT >= 3);
    localparam logic [c_cw-1:0] c_cnt_init = c_use_busy ? c_cw'(MC_LAT - 2) : '0;

    mc_state_t       state_q, state_d;
    logic [c_cw-1:0] cnt_q, cnt_d;

    logic     w_lw_stall;
    logic     w_mc_stall;
    fwd_sel_t w_fwd_a;
    fwd_sel_t w_fwd_b;

    assign w_lw_stall = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

    always_comb begin
        w_fwd_a = fwd_pick(RegWriteM && (RdM != '0) && (RdM == Rs1E),
                           RegWriteW && (RdW != '0) && (RdW == Rs1E));
        w_fwd_b = fwd_pick(RegWriteM && (RdM != '0) && (RdM == Rs2E),
                           RegWriteW && (RdW != '0) && (RdW == Rs2E));
    end

    // The IDLE cycle that accepts the op already stalls, so BUSY covers MC_LAT-2 more.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        w_mc_stall = 1'b0;
        case (state_q)
            MC_IDLE: begin
                if (c_mc_en && McStartE) begin
                    w_mc_stall = 1'b1;
                    if (c_use_busy) begin
                        state_d = MC_BUSY;
                        cnt_d   = c_cnt_init;
                    end else begin
                        state_d = MC_DONE;
                    end
                end
            end
            MC_BUSY: begin
                w_mc_stall = 1'b1;
                if (cnt_q == c_cw'(1))
                    state_d = MC_DONE;
                else
                    cnt_d = cnt_q - 1'b1;
            end
            MC_DONE: begin
                state_d = MC_IDLE;
            end
            default: begin
                state_d = MC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MC_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Everything visible is held low while reset is asserted.
    assign StallF    = !reset && (w_lw_stall || w_mc_stall);
    assign StallD    = StallF;
    assign StallE    = !reset && w_mc_stall;
    assign FlushM    = StallE;
    assign FlushE    = !reset && (w_lw_stall || PCSrcE);
    assign FlushD    = !reset && PCSrcE;
    assign ForwardAE = reset ? FWD_RF : w_fwd_a;
    assign ForwardBE = reset ? FWD_RF : w_fwd_b;
    assign McBusy    = !reset && (state_q != MC_IDLE);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc     (StallF),
        .clr     (CntClr),
        .count_o (StallCnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc     (FlushD),
        .clr     (CntClr),
        .count_o (FlushCnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module  : tb_hazard_ctrl
// Brief   : Self-checking bench for hazard_ctrl (MC_LAT=4/CNT_W=4 and MC_LAT=1).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0, RdM = '0, RdW = '0;
    logic       RegWriteM = 1'b0, RegWriteW = 1'b0, ResultSrcE0 = 1'b0, PCSrcE = 1'b0;
    logic       McStartE = 1'b0, CntClr = 1'b0;

    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy;
    logic [1:0] ForwardAE, ForwardBE;
    logic [3:0] StallCnt, FlushCnt;

    logic       StallF1, StallD1, StallE1, FlushD1, FlushE1, FlushM1, McBusy1;
    logic [1:0] ForwardAE1, ForwardBE1;
    logic [7:0] StallCnt1, FlushCnt1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .MC_LAT(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .McStartE(McStartE), .CntClr(CntClr),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE),
        .FlushM(FlushM), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .McBusy(McBusy),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    hazard_ctrl #(.REG_AW(5), .MC_LAT(1), .CNT_W(8)) dut1 (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .McStartE(McStartE), .CntClr(CntClr),
        .StallF(StallF1), .StallD(StallD1), .StallE(StallE1), .FlushD(FlushD1), .FlushE(FlushE1),
        .FlushM(FlushM1), .ForwardAE(ForwardAE1), .ForwardBE(ForwardBE1), .McBusy(McBusy1),
        .StallCnt(StallCnt1), .FlushCnt(FlushCnt1)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase = cycles already spent by the current multi-cycle op (0 = no op).
    // An op of latency lat stalls while fewer than lat-1 of its cycles have passed.
    function automatic void mc_model(input int lat, input int ph, input bit start,
                                     output bit stall, output int nph);
        if (ph == 0) begin
            stall = start && (lat >= 2);
            nph   = stall ? 1 : 0;
        end else begin
            stall = (ph < lat - 1);
            nph   = stall ? ph + 1 : 0;
        end
    endfunction

    function automatic logic [1:0] fwd_model(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic int sat_next(input int v, input bit inc, input bit clr, input int maxv);
        if (clr) return 0;
        if (inc && v < maxv) return v + 1;
        return v;
    endfunction

    int ph_a = 0, ph_b = 0, sc_a = 0, fc_a = 0, sc_b = 0, fc_b = 0;
    int n_ph_a = 0, n_ph_b = 0, n_sc_a = 0, n_fc_a = 0, n_sc_b = 0, n_fc_b = 0;

    task automatic check_inst(input string tag, input int lat, input int ph, input int sc,
                              input int fc, input int maxv, output int nph, output int nsc,
                              output int nfc, input logic sf, input logic sd, input logic se,
                              input logic fd, input logic fe, input logic fm, input logic mb,
                              input logic [1:0] fa, input logic [1:0] fb,
                              input longint scnt, input longint fcnt);
        bit mcs, lw, e_sf;
        int np;
        mc_model(lat, ph, McStartE, mcs, np);
        lw = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        e_sf = !reset && (lw || mcs);
        check({tag, "StallF"}, sf, e_sf);
        check({tag, "StallD"}, sd, e_sf);
        check({tag, "StallE"}, se, !reset && mcs);
        check({tag, "FlushM"}, fm, !reset && mcs);
        check({tag, "FlushE"}, fe, !reset && (lw || PCSrcE));
        check({tag, "FlushD"}, fd, !reset && PCSrcE);
        check({tag, "McBusy"}, mb, !reset && ph != 0);
        check({tag, "ForwardAE"}, fa, reset ? 0 : fwd_model(Rs1E));
        check({tag, "ForwardBE"}, fb, reset ? 0 : fwd_model(Rs2E));
        check({tag, "StallCnt"}, scnt, reset ? 0 : sc);
        check({tag, "FlushCnt"}, fcnt, reset ? 0 : fc);
        if (reset) begin
            nph = 0; nsc = 0; nfc = 0;
        end else begin
            nph = np;
            nsc = sat_next(sc, e_sf, CntClr, maxv);
            nfc = sat_next(fc, PCSrcE, CntClr, maxv);
        end
    endtask

    always @(negedge clk) begin
        check_inst("A.", 4, ph_a, sc_a, fc_a, 15, n_ph_a, n_sc_a, n_fc_a,
                   StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy,
                   ForwardAE, ForwardBE, longint'(StallCnt), longint'(FlushCnt));
        check_inst("B.", 1, ph_b, sc_b, fc_b, 255, n_ph_b, n_sc_b, n_fc_b,
                   StallF1, StallD1, StallE1, FlushD1, FlushE1, FlushM1, McBusy1,
                   ForwardAE1, ForwardBE1, longint'(StallCnt1), longint'(FlushCnt1));
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ph_a = 0; sc_a = 0; fc_a = 0; ph_b = 0; sc_b = 0; fc_b = 0;
        end else begin
            ph_a = n_ph_a; sc_a = n_sc_a; fc_a = n_fc_a;
            ph_b = n_ph_b; sc_b = n_sc_b; fc_b = n_fc_b;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE0 = 0; PCSrcE = 0; McStartE = 0; CntClr = 0;
    endtask

    int exp_stall[4] = '{1, 1, 1, 0};
    int exp_busy[4]  = '{0, 1, 1, 1};

    initial begin
        idle_inputs();
        #2;
        check("reset_StallF", StallF, 0);
        check("reset_McBusy", McBusy, 0);
        check("reset_StallCnt", StallCnt, 0);
        tick(); tick();
        reset = 0;
        tick();

        // load-use hazard
        ResultSrcE0 = 1; RdE = 5; Rs1D = 5;
        #1;
        check("lw_StallF", StallF, 1);
        check("lw_StallD", StallD, 1);
        check("lw_FlushE", FlushE, 1);
        check("lw_StallE", StallE, 0);
        tick();
        idle_inputs();
        #1 check("lw_one_cycle", StallF, 0);
        tick();
        ResultSrcE0 = 1; RdE = 0; Rs1D = 0;
        #1;
        check("lw_x0_StallF", StallF, 0);
        check("lw_x0_FlushE", FlushE, 0);
        tick();

        // forwarding
        idle_inputs();
        RdM = 7; RdW = 7; RegWriteM = 1; RegWriteW = 1; Rs1E = 7;
        #1 check("fwd_mem", ForwardAE, 2'b10);
        RegWriteM = 0;
        #1 check("fwd_wb", ForwardAE, 2'b01);
        Rs2E = 0; RdM = 0; RegWriteM = 1;
        #1 check("fwd_x0", ForwardBE, 2'b00);
        tick();

        // multi-cycle op
        idle_inputs(); CntClr = 1;
        tick();
        CntClr = 0; McStartE = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("mc_StallF", StallF, exp_stall[i]);
            check("mc_StallE", StallE, exp_stall[i]);
            check("mc_FlushM", FlushM, exp_stall[i]);
            check("mc_McBusy", McBusy, exp_busy[i]);
            check("mc1_StallF", StallF1, 0);
            check("mc1_McBusy", McBusy1, 0);
            tick();
        end
        McStartE = 0;
        #1 check("mc_StallCnt", StallCnt, 3);
        tick();

        // taken branches
        CntClr = 1;
        tick();
        CntClr = 0; PCSrcE = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("br_FlushD", FlushD, 1);
            check("br_FlushE", FlushE, 1);
            check("br_StallF", StallF, 0);
            tick();
        end
        PCSrcE = 0;
        #1 check("br_FlushCnt", FlushCnt, 2);
        PCSrcE = 1; CntClr = 1;
        tick();
        PCSrcE = 0; CntClr = 0;
        #1 check("br_clr_wins", FlushCnt, 0);
        tick();

        // reset in the second BUSY cycle
        McStartE = 1;
        tick(); tick();
        reset = 1;
        #1;
        check("rst_StallF", StallF, 0);
        check("rst_StallE", StallE, 0);
        check("rst_McBusy", McBusy, 0);
        check("rst_StallCnt", StallCnt, 0);
        check("rst_FlushCnt", FlushCnt, 0);
        tick();
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rst_re_StallF", StallF, exp_stall[i]);
            check("rst_re_McBusy", McBusy, exp_busy[i]);
            tick();
        end
        McStartE = 0;
        tick();

        // saturation
        ResultSrcE0 = 1; RdE = 3; Rs2D = 3;
        repeat (20) tick();
        idle_inputs();
        #1 check("sat_StallCnt", StallCnt, 15);
        CntClr = 1;
        tick();
        CntClr = 0;
        #1 check("sat_clr", StallCnt, 0);
        tick();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            Rs1D = 5'($urandom_range(0, 7)); Rs2D = 5'($urandom_range(0, 7));
            Rs1E = 5'($urandom_range(0, 7)); Rs2E = 5'($urandom_range(0, 7));
            RdE  = 5'($urandom_range(0, 7)); RdM  = 5'($urandom_range(0, 7));
            RdW  = 5'($urandom_range(0, 7));
            RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
            CntClr = ($urandom_range(0, 39) == 0);
            ResultSrcE0 = 0; PCSrcE = 0; McStartE = 0;
            if (ph_a != 0) begin
                McStartE = 1;
            end else begin
                case ($urandom_range(0, 9))
                    0, 1:    ResultSrcE0 = 1;
                    2:       PCSrcE = 1;
                    3:       McStartE = 1;
                    default: ;
                endcase
            end
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 0;
        idle_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_AW, default 5, register address width.
REQ-002 Parameter MC_LAT, default 4, number of EX-stage cycles a multi-cycle op occupies (>=1).
REQ-003 Parameter CNT_W, default 32, performance counter width.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 Rs1D, Rs2D  in  REG_AW  Decode source registers.
REQ-007 Rs1E, Rs2E, RdE  in  REG_AW  Execute sources and destination.
REQ-008 RdM, RdW  in  REG_AW  Memory and Writeback destinations.
REQ-009 RegWriteM, RegWriteW  in  1  destination write enables in M and W.
REQ-010 ResultSrcE0  in  1  EX instruction is a load.
REQ-011 PCSrcE  in  1  taken branch/jump in EX.
REQ-012 McStartE  in  1  EX instruction is a multi-cycle op; held while it sits in EX.
REQ-013 CntClr  in  1  synchronous clear of both performance counters.
REQ-014 StallF, StallD, StallE  out  1  hold PC, IF/ID and ID/EX registers.
REQ-015 FlushD, FlushE, FlushM  out  1  bubble IF/ID, ID/EX and EX/MEM registers.
REQ-016 ForwardAE, ForwardBE  out  2  operand select: 00 regfile, 01 W result, 10 M ALU result.
REQ-017 McBusy  out  1  multi-cycle FSM is not IDLE.
REQ-018 StallCnt, FlushCnt  out  CNT_W  saturating stall-cycle and taken-branch counters.

Function
REQ-019 lwStall SHALL be ResultSrcE0 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
REQ-020 ForwardAE SHALL be 10 if RegWriteM & RdM!=0 & RdM==Rs1E; else 01 if RegWriteW & RdW!=0 & RdW==Rs1E; else 00. M has priority over W. ForwardBE is identical using Rs2E.
REQ-021 The FSM SHALL have states IDLE, BUSY and DONE, with a down-counter of width clog2(MC_LAT)+1.
REQ-022 IDLE & McStartE & MC_LAT>=2: mcStall=1; next state is BUSY with cnt=MC_LAT-2 if MC_LAT>=3, else DONE.
REQ-023 BUSY: mcStall=1; if cnt==1 the next state is DONE, else cnt decrements.
REQ-024 DONE: mcStall=0 and McStartE is ignored; next state is IDLE unconditionally.
REQ-025 A multi-cycle op SHALL therefore produce exactly MC_LAT-1 consecutive mcStall cycles. MC_LAT=1 SHALL never leave IDLE and never stall.
REQ-026 StallF = StallD = lwStall | mcStall; StallE = mcStall.
REQ-027 FlushM = mcStall, so a bubble enters M each stall cycle.
REQ-028 FlushE = lwStall | PCSrcE; FlushD = PCSrcE.
REQ-029 FlushE SHALL never assert while mcStall=1. ResultSrcE0, PCSrcE and McStartE are mutually exclusive by construction and are not required to be arbitrated.
REQ-030 McBusy SHALL be 1 in BUSY and DONE.
REQ-031 StallCnt SHALL increment by 1 each cycle StallF=1.
REQ-032 FlushCnt SHALL increment by 1 each cycle PCSrcE=1.
REQ-033 Both counters SHALL saturate at 2^CNT_W-1.
REQ-034 CntClr SHALL zero both counters at the next edge and wins over a simultaneous increment.
REQ-035 All stall, flush and forward outputs other than the FSM and counter state SHALL be combinational, with zero-cycle latency.

Reset
REQ-036 Asserting reset SHALL immediately force state=IDLE, cnt=0 and StallCnt=FlushCnt=0.
REQ-037 While reset=1, all Stall*, Flush* and Forward* outputs and McBusy SHALL be forced to 0.
REQ-038 Reset mid-BUSY SHALL abandon the operation; after release, a held McStartE restarts a full MC_LAT-1 stall.

Structure
REQ-039 Package rvx_hazard_pkg SHALL hold the fwd_sel_t enum (FWD_RF=00, FWD_WB=01, FWD_MEM=10) and the mc_state_t enum.
REQ-040 The saturating counter SHALL be one sub-module, sat_counter (parameter W; inputs inc, clr), instantiated twice.

Verification
REQ-041 ResultSrcE0=1, RdE=5, Rs1D=5 -> StallF=StallD=FlushE=1 for one cycle. Same stimulus with RdE=0, Rs1D=0 -> all 0.
REQ-042 MC_LAT=4, McStartE held 4 cycles -> StallF/D/E=FlushM=1 for exactly 3 cycles and 0 on the 4th; McBusy=1 on cycles 2-4; StallCnt=3.
REQ-043 RdM=RdW=7, RegWriteM=RegWriteW=1, Rs1E=7 -> ForwardAE=10. With RegWriteM=0 -> 01. Rs2E=0, RdM=0, RegWriteM=1 -> ForwardBE=00.
REQ-044 PCSrcE=1 for 2 cycles -> FlushD=FlushE=1 with no stall, FlushCnt=2. CntClr in the same cycle as a PCSrcE pulse -> FlushCnt=0.
REQ-045 Reset asserted in the 2nd BUSY cycle -> stalls drop in the same cycle and counters read 0. After release, with McStartE held -> a fresh 3-cycle stall.
REQ-046 CNT_W=4, 20 stall cycles -> StallCnt=15, no wrap. Then CntClr -> 0 at the next edge.
